// File: rtl/ufm_csr_responder_pkg.sv
// Shared definitions for the UFM CSR responder: register field offsets,
// busy encodings, reset values and the control FSM state type.
package ufm_csr_pkg;

  localparam int unsigned SECTOR_LSB = 20;
  localparam int unsigned WP_LSB     = 23;
  localparam int unsigned ES_BIT     = 4;
  localparam int unsigned SP_LSB     = 5;

  localparam logic [1:0]  BUSY_IDLE   = 2'b00;
  localparam logic [1:0]  BUSY_ERASE  = 2'b01;
  localparam logic [2:0]  SECTOR_NONE = 3'b111;
  localparam logic [31:0] CTRL_RESET  = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    StIdle,
    StErase
  } ufm_state_e;

  // Status word: busy, erase success and a mirror of the write-protect bits.
  function automatic logic [31:0] build_status(logic [1:0] busy, logic es, logic [4:0] wp);
    logic [31:0] s;
    s              = '0;
    s[1:0]         = busy;
    s[ES_BIT]      = es;
    s[SP_LSB +: 5] = wp;
    return s;
  endfunction

endpackage

// File: rtl/ufm_csr_responder_if.sv
// CSR bus between the flash-prep controller (master) and the responder (slave).
interface ufm_csr_responder_if;
  logic        csr_addr;
  logic        csr_read;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;

  modport master (
    output csr_addr, csr_read, csr_write, csr_writedata,
    input  csr_readdata
  );

  modport slave (
    input  csr_addr, csr_read, csr_write, csr_writedata,
    output csr_readdata
  );
endinterface

// File: rtl/ufm_erase_timer.sv
// Loadable down-counter timing one sector erase; done is high in the last busy cycle.
module ufm_erase_timer #(
  parameter int unsigned ERASE_CYCLES = 16,
  localparam int unsigned CntW = $clog2(ERASE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: reload on start, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntW'(ERASE_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CntW'(1));

endmodule

// File: rtl/ufm_csr_responder.sv
// UFM CSR slave: control register, derived status, and sector-erase timing emulation.
module ufm_csr_responder
  import ufm_csr_pkg::*;
#(
  parameter int unsigned ERASE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  ufm_csr_responder_if.slave  csr,
  output logic                erase_busy,
  output logic [2:0]          erase_sector,
  output logic                erase_done
);

  ufm_state_e  state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] rdata_q, rdata_d;
  logic        es_q, es_d;
  logic [2:0]  sector_q, sector_d;
  logic        done_q, done_d;
  logic        timer_load;
  logic        timer_done;

  logic [31:0] status;
  logic [2:0]  sel_new;
  logic [7:0]  wp_by_sector;

  ufm_erase_timer #(
    .ERASE_CYCLES (ERASE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .done (timer_done)
  );

  assign status = build_status((state_q == StErase) ? BUSY_ERASE : BUSY_IDLE, es_q,
                               ctrl_q[WP_LSB +: 5]);

  // Protect bits of the incoming write indexed by sector number; 0, 6, 7 read as protected.
  assign sel_new      = csr.csr_writedata[SECTOR_LSB +: 3];
  assign wp_by_sector = {2'b11, csr.csr_writedata[WP_LSB +: 5], 1'b1};

  // Next-state logic for the FSM, control register, read data and erase outputs.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    es_d       = es_q;
    sector_d   = sector_q;
    done_d     = 1'b0;
    timer_load = 1'b0;
    rdata_d    = rdata_q;

    // Reads see the pre-write register contents.
    if (csr.csr_read) begin
      rdata_d = csr.csr_addr ? ctrl_q : status;
    end

    unique case (state_q)
      StIdle: begin
        if (csr.csr_write && csr.csr_addr) begin
          ctrl_d = csr.csr_writedata;
          if (sel_new != SECTOR_NONE) begin
            es_d = 1'b0;
            if (!wp_by_sector[sel_new]) begin
              state_d    = StErase;
              timer_load = 1'b1;
              sector_d   = sel_new;
            end
          end
        end
      end
      StErase: begin
        if (timer_done) begin
          state_d = StIdle;
          es_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ctrl_q   <= CTRL_RESET;
      rdata_q  <= '0;
      es_q     <= 1'b0;
      sector_q <= SECTOR_NONE;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      rdata_q  <= rdata_d;
      es_q     <= es_d;
      sector_q <= sector_d;
      done_q   <= done_d;
    end
  end

  assign csr.csr_readdata = rdata_q;
  assign erase_busy       = (state_q == StErase);
  assign erase_sector     = sector_q;
  assign erase_done       = done_q;

endmodule

// File: tb/tb_ufm_csr_responder.sv
// Self-checking bench for ufm_csr_responder with ERASE_CYCLES = 16.
module tb_ufm_csr_responder;

  localparam int unsigned ErCycles = 16;

  logic       clk;
  logic       rst;
  logic       erase_busy;
  logic [2:0] erase_sector;
  logic       erase_done;

  ufm_csr_responder_if csr ();

  ufm_csr_responder #(
    .ERASE_CYCLES (ErCycles)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csr          (csr),
    .erase_busy   (erase_busy),
    .erase_sector (erase_sector),
    .erase_done   (erase_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        do_wr;
    logic        waddr;
    logic [31:0] wdata;
    logic        raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[6];

  // Observe erase outputs mid-cycle.
  always @(negedge clk) begin
    if (erase_busy) busy_cnt++;
    if (erase_done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic addr, input logic [31:0] data);
    csr.csr_addr      = addr;
    csr.csr_writedata = data;
    csr.csr_write     = 1'b1;
    tick();
    csr.csr_write     = 1'b0;
  endtask

  // Issue a read; the expected word goes to the scoreboard and is compared one cycle later.
  task automatic do_read(input logic addr, input logic [31:0] exp, input string name);
    csr.csr_addr = addr;
    csr.csr_read = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick();
    csr.csr_read = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      check(name_q.pop_front(), csr.csr_readdata, exp_q.pop_front());
    end
  endtask

  initial begin
    rst               = 1'b1;
    csr.csr_addr      = 1'b0;
    csr.csr_read      = 1'b0;
    csr.csr_write     = 1'b0;
    csr.csr_writedata = '0;

    vecs[0] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_03E0, "reset_status"};
    vecs[1] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFF, "reset_ctrl"};
    vecs[2] = '{1'b1, 1'b1, 32'hFF7F_FFFF, 1'b0, 32'h0000_03C0, "unprot_status"};
    vecs[3] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hFF7F_FFFF, "unprot_ctrl"};
    vecs[4] = '{1'b1, 1'b0, 32'h1234_5678, 1'b1, 32'hFF7F_FFFF, "addr0_write_ignored"};
    vecs[5] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_03C0, "status_idle"};

    repeat (2) tick();
    rst = 1'b0;
    check("rst_readdata", csr.csr_readdata, 32'h0);
    check("rst_busy", {31'b0, erase_busy}, 32'h0);
    check("rst_sector", {29'b0, erase_sector}, 32'h7);
    check("rst_done", {31'b0, erase_done}, 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) do_write(vecs[i].waddr, vecs[i].wdata);
      do_read(vecs[i].raddr, vecs[i].exp, vecs[i].name);
    end

    // Sector 1 erase: write in cycle N.
    busy_cnt = 0;
    done_cnt = 0;
    do_write(1'b1, 32'hFF1F_FFFF);                         // now N+1
    check("erase_busy_start", {31'b0, erase_busy}, 32'h1);
    check("erase_sector_1", {29'b0, erase_sector}, 32'h1);
    do_read(1'b0, 32'h0000_03C1, "status_busy");          // N+1
    do_write(1'b1, 32'hFFFF_FFFF);                         // N+2, ignored
    do_read(1'b1, 32'hFF1F_FFFF, "ctrl_locked");          // N+3
    repeat (ErCycles - 4) tick();                          // now N+16
    do_read(1'b0, 32'h0000_03C1, "status_last_busy");     // N+16
    check("done_pulse", {31'b0, erase_done}, 32'h1);       // N+17
    check("busy_dropped", {31'b0, erase_busy}, 32'h0);
    do_read(1'b0, 32'h0000_03D0, "status_es");            // N+17
    check("done_one_cycle", {31'b0, erase_done}, 32'h0);
    check("busy_cycles", busy_cnt, ErCycles);
    check("done_count", done_cnt, 32'd1);
    do_write(1'b1, 32'hFF7F_FFFF);
    do_read(1'b0, 32'h0000_03D0, "none_keeps_es");
    check("sector_kept", {29'b0, erase_sector}, 32'h1);

    // Protected sector 2: no erase, es cleared.
    busy_cnt = 0;
    done_cnt = 0;
    do_write(1'b1, 32'hFF2F_FFFF);
    repeat (ErCycles + 4) tick();
    do_read(1'b0, 32'h0000_03C0, "prot_status");
    check("prot_busy_cycles", busy_cnt, 32'd0);
    check("prot_done_count", done_cnt, 32'd0);

    // Back-to-back erases, then reset in the fifth busy cycle of the second.
    do_write(1'b1, 32'hFF1F_FFFF);                         // N+1
    repeat (ErCycles) tick();                              // N+17
    check("b2b_done", {31'b0, erase_done}, 32'h1);
    do_write(1'b1, 32'hFF1F_FFFF);                         // M=N+17, now M+1
    check("b2b_busy", {31'b0, erase_busy}, 32'h1);
    done_cnt = 0;
    repeat (4) tick();                                     // M+5
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'b0, erase_busy}, 32'h0);
    check("abort_sector", {29'b0, erase_sector}, 32'h7);
    check("abort_readdata", csr.csr_readdata, 32'h0);
    repeat (ErCycles + 4) tick();
    check("abort_no_done", done_cnt, 32'd0);
    do_read(1'b0, 32'h0000_03E0, "abort_status");
    do_read(1'b1, 32'hFFFF_FFFF, "abort_ctrl");
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
